// File: rtl/mux_nx1_rr_stream.sv
// -----------------------------------------------------------------------------
// mux_nx1_rr_stream
//
// N-channel, DATA_W-bit streaming multiplexer with a registered output.
// Channels are selected either by an external index (fixed mode) or by a
// round-robin arbiter whose pointer advances past each served channel.
// The output register accepts a new word whenever it is empty or being
// drained, so a continuously ready consumer sees one word per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mode       0 = round-robin arbitration, 1 = fixed select
//   sel        channel index used in fixed mode (>= NUM_CH grants nothing)
//   in_data    packed channel data, channel k at [k*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected word
//   out_ch     channel index of out_data
//   out_valid  out_data/out_ch hold a word
//   out_ready  consumer accepts the word
// -----------------------------------------------------------------------------
module mux_nx1_rr_stream #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Vectors indexed by a SEL_W-bit channel number are padded to the full
  // index range so a non-power-of-two NUM_CH never indexes past the end.
  localparam int PAD_W = 1 << SEL_W;

  logic [SEL_W-1:0]  rr_ptr;

  logic              load_en_p0;
  logic              grant_vld_p0;
  logic [SEL_W-1:0]  grant_ch_p0;
  logic              sel_in_range_p0;
  logic [PAD_W-1:0]  valid_pad_p0;
  logic [PAD_W-1:0]  ready_pad_p0;
  logic [NUM_CH-1:0] rot_valid_p0;
  logic              rr_found_p0;
  logic [SEL_W-1:0]  rr_off_p0;
  logic [SEL_W:0]    rr_sum_p0;
  logic [DATA_W-1:0] ch_data_p0 [PAD_W];

  // Channel after ch, wrapping NUM_CH-1 back to 0.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] ch);
    if (ch == SEL_W'(NUM_CH - 1)) begin
      return '0;
    end
    return ch + 1'b1;
  endfunction

  // Unpack the channel words; unused padding entries read as zero.
  for (genvar k = 0; k < PAD_W; k++) begin : g_unpack
    if (k < NUM_CH) begin : g_real
      assign ch_data_p0[k] = in_data[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign ch_data_p0[k] = '0;
    end
  end

  // ---- stage p0: combinational grant from current inputs and rr_ptr ----
  assign load_en_p0      = !out_valid || out_ready;
  assign valid_pad_p0    = PAD_W'(in_valid);
  assign sel_in_range_p0 = {1'b0, sel} < (SEL_W+1)'(NUM_CH);

  // Rotating the doubled valid vector puts the channel at rr_ptr in bit 0,
  // so the lowest set bit is the first valid channel in round-robin order.
  assign rot_valid_p0 = NUM_CH'({in_valid, in_valid} >> rr_ptr);

  always_comb begin
    rr_found_p0 = 1'b0;
    rr_off_p0   = '0;
    // Scan from the top so the lowest offset is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_valid_p0[i]) begin
        rr_found_p0 = 1'b1;
        rr_off_p0   = SEL_W'(i);
      end
    end
  end

  assign rr_sum_p0 = {1'b0, rr_ptr} + {1'b0, rr_off_p0};

  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_ch_p0  = '0;
    if (mode) begin
      if (sel_in_range_p0 && valid_pad_p0[sel]) begin
        grant_vld_p0 = 1'b1;
        grant_ch_p0  = sel;
      end
    end else if (rr_found_p0) begin
      grant_vld_p0 = 1'b1;
      grant_ch_p0  = (rr_sum_p0 >= (SEL_W+1)'(NUM_CH))
                   ? SEL_W'(rr_sum_p0 - (SEL_W+1)'(NUM_CH))
                   : SEL_W'(rr_sum_p0);
    end
  end

  // Ready only to the granted channel, and only when the output register
  // can take the word; nothing is accepted while reset is asserted.
  always_comb begin
    ready_pad_p0 = '0;
    if (!rst && load_en_p0 && grant_vld_p0) begin
      ready_pad_p0[grant_ch_p0] = 1'b1;
    end
  end

  assign in_ready = ready_pad_p0[NUM_CH-1:0];

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_en_p0) begin
      if (grant_vld_p0) begin
        out_valid <= 1'b1;
        out_data  <= ch_data_p0[grant_ch_p0];
        out_ch    <= grant_ch_p0;
        if (!mode) begin
          rr_ptr <= wrap_inc(grant_ch_p0);
        end
      end else begin
        // Drain: the word is gone but data/channel keep their last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_nx1_rr_stream.md
Name: mux_nx1_rr_stream

Overview:
Parametrised N-channel, W-bit streaming multiplexer. It generalises the 8x1 bit mux to multi-bit channels with valid/ready handshakes and a registered output. It has two select modes: fixed (external select, like the mux family) and round-robin arbitration. It sits between several producer channels and a single consumer, for example a shared UART/FIFO sink.

Parameters:
NUM_CH, 8, number of input channels (2..32; need not be a power of two)
DATA_W, 8, width of each channel's data word
SEL_W, $clog2(NUM_CH), width of the select and channel-ID fields (derived; do not override)

Ports:
clk  input  1  single clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
mode  input  1  0 = round-robin arbitration, 1 = fixed select
sel  input  SEL_W  channel index used when mode=1
in_data  input  NUM_CH*DATA_W  packed channel data; channel k is at [k*DATA_W +: DATA_W]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready; one-hot or zero
out_data  output  DATA_W  registered selected word
out_ch  output  SEL_W  channel index of out_data
out_valid  output  1  out_data/out_ch hold a word
out_ready  input  1  consumer accepts the word

Behaviour:
- Reset is synchronous and active-high, applied on the clk edge with rst=1.
  - Values after reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is 0 while rst=1.
- load_en = !out_valid || out_ready. The output register can accept a word this cycle if it is empty or draining.
- Grant selection (combinational, evaluated every cycle):
  - mode=1: grant sel if in_valid[sel]=1 and sel<NUM_CH. Otherwise no grant. If sel>=NUM_CH, nothing is ever granted.
  - mode=0: grant the first k with in_valid[k]=1, scanning from rr_ptr upward and wrapping NUM_CH-1 -> 0. No valid inputs means no grant.
- in_ready[g] = load_en && granted(g). All other in_ready bits are 0.
  - in_ready depends combinationally on in_valid, mode, sel and out_ready.
  - Producers must not make in_valid depend on in_ready.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= channel g data; out_ch <= g; out_valid <= 1.
  - If mode=0: rr_ptr <= (g+1) mod NUM_CH.
  - If mode=1: rr_ptr is unchanged.
- Transfer latency is 1 cycle, input to out_valid. Throughput is 1 word/cycle with out_ready held high.
- If load_en=1 and there is no grant, out_valid <= 0 at the next edge (the output drains). out_data and out_ch keep their last value.
- If out_valid=1 and out_ready=0:
  - out_data, out_ch and out_valid are held stable.
  - All in_ready are 0.
  - Producers holding in_valid are not lost.
- Simultaneous drain and refill (out_valid=1, out_ready=1, valid grant) gives a back-to-back word with no bubble.
- Mode or sel changes take effect in the same cycle's grant. The word already in the output register is unaffected.
- Fairness: in mode=0 with all channels continuously valid, the grant order is 0,1,...,NUM_CH-1,0,... Any continuously valid channel is served within NUM_CH transfers.
- Reset mid-stream discards the held output word (out_valid=0 next cycle). No input is accepted in the reset cycle.
- No other internal state beyond the output register and rr_ptr.

Test Plan:
1. Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. First grant after release is channel 0 (mode=0).
2. Fixed sweep (NUM_CH=8, DATA_W=8):
   - Stimulus: channel k data = 8'h10+k, in_valid=8'hFF, mode=1, out_ready=1, sel stepping 0..7 each cycle.
   - Expected: out_data = 8'h10..8'h17 one cycle after each sel, out_ch tracks sel, in_ready one-hot = 1<<sel.
3. Round-robin, all valid:
   - Stimulus: mode=0, in_valid=8'hFF, out_ready=1 for 10 cycles.
   - Expected: out_ch sequence 0,1,2,3,4,5,6,7,0,1 with no bubbles.
4. Sparse round-robin:
   - Stimulus: in_valid=8'b1001_0010 held, mode=0.
   - Expected: out_ch sequence 1,4,7,1,4 and no grants to other channels.
5. Backpressure:
   - Stimulus: mode=0, all valid; after the first word, out_ready=0 for 3 cycles, then 1.
   - Expected: out_data/out_ch frozen for those 3 cycles, in_ready=0 throughout, next out_ch = previous+1 (nothing skipped).
6. Edge cases:
   - NUM_CH=6, mode=1, sel=3'd7, in_valid all 1 -> no grant, out_valid falls to 0.
   - Assert rst with out_valid=1, out_ready=0 -> out_valid=0 next cycle and rr_ptr back to 0.
